nonce_scheduler: RTL and testbench
==================================

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 SHALL have parameter LOG2_CORES, default 2, log2 of hasher core count; NCORES = 2**LOG2_CORES, legal 1..16.
REQ-002 SHALL have port CLK  in  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have port job_valid  in  1, and job_ready  out  1: job handshake, transfer when both high.
REQ-005 SHALL have port job_midstate  in  256, job_data  in  96, job_noncemin  in  32, job_noncemax  in  32: job fields, sampled on transfer.
REQ-006 SHALL have port core_midstate  out  256, and core_data  out  96: registered job fields, broadcast to all cores.
REQ-007 SHALL have port core_start  out  NCORES, and core_abort  out  NCORES: one-cycle pulses per core.
REQ-008 SHALL have port core_nstart  out  32*NCORES, and core_nend  out  32*NCORES: per-core inclusive nonce range, core i at bits [32i+31:32i].
REQ-009 SHALL have port core_busy  in  NCORES: core searching; asserted the cycle after start, low after abort.
REQ-010 SHALL have port core_found  in  NCORES, core_golden  in  32*NCORES, and core_ack  out  NCORES: per-core golden-nonce valid/data/ack.
REQ-011 SHALL have port gn_valid  out  1, gn_nonce  out  32, and gn_ready  in  1: merged golden-nonce stream toward the UART transmitter.
REQ-012 SHALL have port job_done  out  1: one-cycle pulse when the whole range is exhausted.

Function
REQ-013 SHALL run FSM IDLE -> SPLIT -> START -> RUN -> IDLE; job_ready high in IDLE and RUN only.
REQ-014 SHALL, on job transfer, register all job fields and enter SPLIT; a transfer in RUN SHALL also pulse core_abort (all ones) in the same cycle.
REQ-015 SHALL in SPLIT compute total = noncemax - noncemin + 1 in 33 bits and chunk = total >> LOG2_CORES (33 bits).
REQ-016 SHALL set core i range start = noncemin + i*chunk, end = start + chunk - 1; last core end = noncemax, absorbing the remainder.
REQ-017 SHALL, if chunk == 0, give core 0 the whole range and start no other core.
REQ-018 SHALL, if noncemin > noncemax, start no core, pulse job_done one cycle after SPLIT, and return to IDLE.
REQ-019 SHALL pulse core_start for all started cores in the START state, exactly one cycle, with ranges already stable; SPLIT+START latency SHALL be 2 cycles after transfer.
REQ-020 SHALL in RUN, from the second RUN cycle on, pulse job_done and go IDLE when all started cores have busy low and no golden nonce is pending.
REQ-021 SHALL arbitrate core_found round-robin: priority starts at the core after the last granted core; pointer reset value is 0.
REQ-022 SHALL capture the granted nonce into the gn_nonce register only when the output is empty, or is emptied in the same cycle (gn_valid & gn_ready), and SHALL pulse core_ack for that core in the capture cycle.
REQ-023 SHALL hold gn_valid and gn_nonce stable until gn_ready; throughput one nonce per cycle.
REQ-024 SHALL, on abort, drop all core_found requests during the abort cycle and ack them; a nonce already in the output register SHALL still be delivered.

Reset
REQ-025 SHALL reset: FSM to IDLE; job_ready 1; core_start, core_abort, core_ack, gn_valid, job_done 0; gn_nonce, core ranges, core_midstate, core_data 0; RR pointer 0.
REQ-026 SHALL, on reset mid-RUN, not pulse core_abort; cores SHALL share RST.

Structure
REQ-027 SHALL take the FSM state encodings and the NONCE_W=32, MIDSTATE_W=256, DATA_W=96 constants from the shared miner package.
REQ-028 SHALL place the round-robin arbiter and output register in sub-module gn_arbiter.

Verification
REQ-029 SHALL test: LOG2_CORES=2, min 1DAC2B7B, max FFFFFFFF -> starts 1DAC2B7B/5641209C/8ED615BD/C76B0ADE, ends 5641209B/8ED615BC/C76B0ADD/FFFFFFFF.
REQ-030 SHALL test: min 00000000, max FFFFFFFF -> chunk 40000000, core3 range C0000000..FFFFFFFF, no 33-bit overflow.
REQ-031 SHALL test: min 00000010, max 00000011 (total 2 < 4) -> only core 0 started, range 10..11.
REQ-032 SHALL test: core1 and core3 found in the same cycle with the pointer at 0, and gn_ready low for 3 cycles -> core1 nonce first and held stable, then core3; one core_ack each.
REQ-033 SHALL test: new job mid-RUN -> core_abort 1111 in the transfer cycle, new core_start 2 cycles later, no job_done for the old job.
REQ-034 SHALL test: min > max -> no core_start, job_done pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/nonce_scheduler_pkg.sv
// Shared miner definitions: field widths and scheduler FSM encoding.
package nonce_scheduler_pkg;
  localparam int NONCE_W    = 32;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_START = 2'd2,
    ST_RUN   = 2'd3
  } sched_state_t;
endpackage

// File: rtl/nonce_scheduler_gn_arbiter.sv
// Round-robin merge of per-core golden nonces into one valid/ready stream
// held in a single output register.
module gn_arbiter
  import nonce_scheduler_pkg::*;
#(
  parameter int NCORES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_abort,
  input  logic [NCORES-1:0]         i_core_found,
  input  logic [NONCE_W*NCORES-1:0] i_core_golden,
  output logic [NCORES-1:0]         o_core_ack,
  output logic                      o_gn_valid,
  output logic [NONCE_W-1:0]        o_gn_nonce,
  input  logic                      i_gn_ready
);
  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic               r_valid;
  logic [NONCE_W-1:0] r_nonce;

  logic [PTR_W-1:0]   w_rot  [NCORES];
  logic [NONCE_W-1:0] w_gold [NCORES];
  logic [PTR_W-1:0]   w_grant;
  logic [PTR_W-1:0]   w_ptr_next;
  logic               w_hit;
  logic               w_take;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign w_rot[gi]  = PTR_W'((int'(r_ptr) + gi) % NCORES);
      assign w_gold[gi] = i_core_golden[gi*NONCE_W +: NONCE_W];
    end
  endgenerate

  // First requester scanning upward from the pointer, wrapping around.
  always_comb begin
    w_hit   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!w_hit && i_core_found[w_rot[k]]) begin
        w_hit   = 1'b1;
        w_grant = w_rot[k];
      end
    end
  end

  assign w_take     = w_hit && !i_abort && (!r_valid || i_gn_ready);
  assign w_ptr_next = (w_grant == PTR_W'(NCORES - 1)) ? '0 : w_grant + 1'b1;
  assign o_core_ack = i_abort ? i_core_found
                    : (w_take ? (NCORES'(1) << w_grant) : '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_nonce <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_nonce <= w_gold[w_grant];
      r_ptr   <= w_ptr_next;
    end else if (i_gn_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_gn_valid = r_valid;
  assign o_gn_nonce = r_nonce;
endmodule

// File: rtl/nonce_scheduler.sv
// Splits a job's nonce range across NCORES hasher cores, starts/aborts them,
// and merges their golden nonces into one output stream.
module nonce_scheduler
  import nonce_scheduler_pkg::*;
#(
  parameter  int LOG2_CORES = 2,
  localparam int NCORES     = 1 << LOG2_CORES
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [MIDSTATE_W-1:0]     job_midstate,
  input  logic [DATA_W-1:0]         job_data,
  input  logic [NONCE_W-1:0]        job_noncemin,
  input  logic [NONCE_W-1:0]        job_noncemax,
  output logic [MIDSTATE_W-1:0]     core_midstate,
  output logic [DATA_W-1:0]         core_data,
  output logic [NCORES-1:0]         core_start,
  output logic [NCORES-1:0]         core_abort,
  output logic [NONCE_W*NCORES-1:0] core_nstart,
  output logic [NONCE_W*NCORES-1:0] core_nend,
  input  logic [NCORES-1:0]         core_busy,
  input  logic [NCORES-1:0]         core_found,
  input  logic [NONCE_W*NCORES-1:0] core_golden,
  output logic [NCORES-1:0]         core_ack,
  output logic                      gn_valid,
  output logic [NONCE_W-1:0]        gn_nonce,
  input  logic                      gn_ready,
  output logic                      job_done
);
  sched_state_t          r_state;
  logic [NONCE_W-1:0]    r_min, r_max;
  logic [MIDSTATE_W-1:0] r_midstate;
  logic [DATA_W-1:0]     r_data;
  logic [NCORES-1:0]     r_started, r_start;
  logic                  r_done, r_run_first;

  logic              w_xfer, w_abort, w_empty, w_single, w_quiet;
  logic [NONCE_W:0]  w_total, w_chunk;

  assign job_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_xfer    = job_valid && job_ready;
  // Abort is combinational so it lands in the very cycle the new job is taken.
  assign w_abort   = w_xfer && (r_state == ST_RUN) && !RST;
  assign core_abort = {NCORES{w_abort}};

  assign w_total  = {1'b0, r_max} - {1'b0, r_min} + 33'd1;
  assign w_chunk  = w_total >> LOG2_CORES;
  assign w_empty  = r_min > r_max;
  assign w_single = (w_chunk == '0);
  assign w_quiet  = ((core_busy & r_started) == '0) && !(|core_found) && !gn_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_range
      logic [NONCE_W+4:0] w_off;
      logic [NONCE_W-1:0] w_s, w_e;
      logic [NONCE_W-1:0] r_nstart, r_nend;

      assign w_off = (NONCE_W + 5)'(gi) * {4'd0, w_chunk};

      always_comb begin
        w_s = r_min + w_off[NONCE_W-1:0];
        w_e = (gi == NCORES - 1) ? r_max : w_s + w_chunk[NONCE_W-1:0] - 1'b1;
        if (w_single) begin
          w_s = (gi == 0) ? r_min : '0;
          w_e = (gi == 0) ? r_max : '0;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_nstart <= '0;
          r_nend   <= '0;
        end else if (r_state == ST_SPLIT) begin
          r_nstart <= w_s;
          r_nend   <= w_e;
        end
      end

      assign core_nstart[gi*NONCE_W +: NONCE_W] = r_nstart;
      assign core_nend[gi*NONCE_W +: NONCE_W]   = r_nend;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_min       <= '0;
      r_max       <= '0;
      r_midstate  <= '0;
      r_data      <= '0;
      r_started   <= '0;
      r_start     <= '0;
      r_done      <= 1'b0;
      r_run_first <= 1'b0;
    end else begin
      r_start <= '0;
      r_done  <= 1'b0;
      if (w_xfer) begin
        r_min      <= job_noncemin;
        r_max      <= job_noncemax;
        r_midstate <= job_midstate;
        r_data     <= job_data;
        r_state    <= ST_SPLIT;
      end else begin
        case (r_state)
          ST_SPLIT: begin
            if (w_empty) begin
              r_started <= '0;
              r_done    <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_started <= w_single ? NCORES'(1) : '1;
              r_start   <= w_single ? NCORES'(1) : '1;
              r_state   <= ST_START;
            end
          end
          ST_START: begin
            r_run_first <= 1'b1;
            r_state     <= ST_RUN;
          end
          ST_RUN: begin
            // Cores raise busy only the cycle after start, so skip the first RUN cycle.
            r_run_first <= 1'b0;
            if (!r_run_first && w_quiet) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign core_midstate = r_midstate;
  assign core_data     = r_data;
  assign core_start    = r_start;
  assign job_done      = r_done;

  gn_arbiter #(.NCORES(NCORES)) u_gn_arbiter (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_abort       (w_abort),
    .i_core_found  (core_found),
    .i_core_golden (core_golden),
    .o_core_ack    (core_ack),
    .o_gn_valid    (gn_valid),
    .o_gn_nonce    (gn_nonce),
    .i_gn_ready    (gn_ready)
  );
endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: range splitting, start/done timing,
// golden-nonce arbitration, abort and reset behaviour.
module tb_nonce_scheduler;
  localparam int L2 = 2;
  localparam int NC = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          job_valid, job_ready;
  logic [255:0]  job_midstate, core_midstate;
  logic [95:0]   job_data, core_data;
  logic [31:0]   job_noncemin, job_noncemax;
  logic [NC-1:0] core_start, core_abort, core_busy, core_found, core_ack;
  logic [32*NC-1:0] core_nstart, core_nend, core_golden;
  logic          gn_valid, gn_ready, job_done;
  logic [31:0]   gn_nonce;

  int errors = 0;
  int checks = 0;

  logic [NC-1:0] exp_mask;
  logic [31:0]   exp_s [NC];
  logic [31:0]   exp_e [NC];
  logic [255:0]  exp_mid;
  logic [95:0]   exp_data;

  always #5 CLK = ~CLK;

  nonce_scheduler #(.LOG2_CORES(L2)) dut (
    .CLK(CLK), .RST(RST), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_data(job_data),
    .job_noncemin(job_noncemin), .job_noncemax(job_noncemax),
    .core_midstate(core_midstate), .core_data(core_data),
    .core_start(core_start), .core_abort(core_abort),
    .core_nstart(core_nstart), .core_nend(core_nend),
    .core_busy(core_busy), .core_found(core_found), .core_golden(core_golden),
    .core_ack(core_ack), .gn_valid(gn_valid), .gn_nonce(gn_nonce),
    .gn_ready(gn_ready), .job_done(job_done)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Reference split: plain 64-bit arithmetic on the job range.
  function automatic void ref_split(input logic [31:0] mn, input logic [31:0] mx);
    longint total, chunk;
    exp_mask = '0;
    for (int i = 0; i < NC; i++) begin exp_s[i] = '0; exp_e[i] = '0; end
    if (mn > mx) return;
    total = longint'(mx) - longint'(mn) + 1;
    chunk = total / NC;
    if (chunk == 0) begin
      exp_mask = 4'b0001; exp_s[0] = mn; exp_e[0] = mx;
    end else begin
      exp_mask = '1;
      for (int i = 0; i < NC; i++) begin
        exp_s[i] = 32'(longint'(mn) + i * chunk);
        exp_e[i] = (i == NC - 1) ? mx : 32'(longint'(mn) + (i + 1) * chunk - 1);
      end
    end
  endfunction

  task automatic do_reset();
    RST = 1'b1; job_valid = 1'b0; core_busy = '0; core_found = '0;
    core_golden = '0; gn_ready = 1'b1; job_midstate = '0; job_data = '0;
    job_noncemin = '0; job_noncemax = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
    checks++; if ({core_start, core_abort, core_ack} !== '0) begin errors++; $display("FAIL reset_pulses: got %b expected 0", {core_start, core_abort, core_ack}); end
    checks++; if ({gn_valid, job_done} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {gn_valid, job_done}); end
    checks++; if (gn_nonce !== '0) begin errors++; $display("FAIL reset_gn_nonce: got %h expected 0", gn_nonce); end
    checks++; if ({core_nstart, core_nend} !== '0) begin errors++; $display("FAIL reset_ranges: got %h expected 0", {core_nstart, core_nend}); end
    checks++; if ({core_midstate, core_data} !== '0) begin errors++; $display("FAIL reset_job_regs: got %h expected 0", {core_midstate, core_data}); end
  endtask

  task automatic drive_job(input logic [31:0] mn, input logic [31:0] mx);
    ref_split(mn, mx);
    for (int i = 0; i < 8; i++) job_midstate[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) job_data[32*i +: 32] = $urandom;
    exp_mid = job_midstate; exp_data = job_data;
    job_noncemin = mn; job_noncemax = mx; job_valid = 1'b1;
  endtask

  // Called in the cycle two after transfer: START (or the done pulse for an empty range).
  task automatic check_start(input string tag);
    checks++; if (core_start !== exp_mask) begin errors++; $display("FAIL %s start_mask: got %b expected %b", tag, core_start, exp_mask); end
    checks++; if (job_done !== (exp_mask == '0)) begin errors++; $display("FAIL %s done_at_start: got %b expected %b", tag, job_done, exp_mask == '0); end
    if (exp_mask != '0) begin
      checks++; if (core_midstate !== exp_mid || core_data !== exp_data) begin errors++; $display("FAIL %s job_fields: got %h expected %h", tag, core_data, exp_data); end
    end
    for (int i = 0; i < NC; i++) begin
      if (exp_mask[i]) begin
        checks++; if (core_nstart[32*i +: 32] !== exp_s[i]) begin errors++; $display("FAIL %s nstart%0d: got %h expected %h", tag, i, core_nstart[32*i +: 32], exp_s[i]); end
        checks++; if (core_nend[32*i +: 32] !== exp_e[i]) begin errors++; $display("FAIL %s nend%0d: got %h expected %h", tag, i, core_nend[32*i +: 32], exp_e[i]); end
      end
    end
  endtask

  task automatic start_job(input logic [31:0] mn, input logic [31:0] mx, input string tag);
    int k;
    drive_job(mn, mx);
    k = 0;
    while (job_ready !== 1'b1 && k < 20) begin tick(); k++; end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL %s ready_timeout: got %b expected 1", tag, job_ready); end
    tick();
    job_valid = 1'b0;
    checks++; if (core_start !== '0) begin errors++; $display("FAIL %s start_early: got %b expected 0", tag, core_start); end
    tick();
    check_start(tag);
  endtask

  task automatic finish_job(input string tag);
    int  hold;
    bit  seen;
    tick();
    core_busy = exp_mask;
    hold = $urandom_range(1, 5);
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++; if (job_done !== 1'b0) begin errors++; $display("FAIL %s early_done: got %b expected 0", tag, job_done); end
    end
    core_busy = '0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (job_done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL %s done_timeout: got 0 expected 1", tag); end
    tick();
    checks++; if (job_done !== 1'b0 || job_ready !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %b%b expected 01", tag, job_done, job_ready); end
  endtask

  task automatic run_full(input logic [31:0] mn, input logic [31:0] mx, input string tag);
    start_job(mn, mx, tag);
    if (exp_mask != '0) finish_job(tag);
    else begin
      tick();
      checks++; if (job_done !== 1'b0 || job_ready !== 1'b1 || core_start !== '0) begin errors++; $display("FAIL %s empty_return: got %b%b%b expected 010", tag, job_done, job_ready, core_start); end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] s29 [4] = '{32'h1DAC2B7B, 32'h5641209C, 32'h8ED615BD, 32'hC76B0ADE};
    logic [31:0] e29 [4] = '{32'h5641209B, 32'h8ED615BC, 32'hC76B0ADD, 32'hFFFFFFFF};
    start_job(32'h1DAC2B7B, 32'hFFFFFFFF, "vec29");
    for (int i = 0; i < NC; i++) begin
      checks++; if (core_nstart[32*i +: 32] !== s29[i] || core_nend[32*i +: 32] !== e29[i]) begin errors++; $display("FAIL vec29_core%0d: got %h..%h expected %h..%h", i, core_nstart[32*i +: 32], core_nend[32*i +: 32], s29[i], e29[i]); end
    end
    finish_job("vec29");
    start_job(32'h00000000, 32'hFFFFFFFF, "vec30");
    checks++; if (core_nstart[96 +: 32] !== 32'hC0000000 || core_nend[96 +: 32] !== 32'hFFFFFFFF || core_nend[0 +: 32] !== 32'h3FFFFFFF) begin errors++; $display("FAIL vec30_ranges: got %h..%h expected C0000000..FFFFFFFF", core_nstart[96 +: 32], core_nend[96 +: 32]); end
    finish_job("vec30");
    start_job(32'h00000010, 32'h00000011, "vec31");
    checks++; if (core_start !== 4'b0001 || core_nstart[0 +: 32] !== 32'h10 || core_nend[0 +: 32] !== 32'h11) begin errors++; $display("FAIL vec31_single: got %b %h..%h expected 0001 10..11", core_start, core_nstart[0 +: 32], core_nend[0 +: 32]); end
    finish_job("vec31");
  endtask

  task automatic test_min_gt_max();
    run_full(32'h00000100, 32'h000000FF, "min_gt_max");
  endtask

  task automatic test_random_jobs();
    logic [31:0] a, b, mn, mx;
    for (int n = 0; n < 16; n++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        0: begin mn = a; mx = b; end
        1: begin mn = a; mx = a + 32'($urandom_range(0, 5)); end
        2: begin mn = (a < b) ? a : b; mx = (a < b) ? b : a; end
        default: begin mn = (a < b) ? b : a; mx = (a < b) ? a : b; end
      endcase
      run_full(mn, mx, "random_job");
    end
  endtask

  task automatic test_arb_order();
    int acks1 = 0, acks3 = 0;
    do_reset();
    gn_ready = 1'b0;
    core_golden[32 +: 32] = 32'hA1A10001;
    core_golden[96 +: 32] = 32'hA3A30003;
    core_found = 4'b1010;
    #1;
    checks++; if (core_ack !== 4'b0010) begin errors++; $display("FAIL arb_first_ack: got %b expected 0010", core_ack); end
    acks1 += core_ack[1]; acks3 += core_ack[3];
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) core_found = 4'b1000;
      if (c == 2) gn_ready = 1'b1;
      #1;
      checks++; if (gn_valid !== 1'b1 || gn_nonce !== 32'hA1A10001) begin errors++; $display("FAIL arb_hold_c%0d: got %b %h expected 1 a1a10001", c, gn_valid, gn_nonce); end
      acks1 += core_ack[1]; acks3 += core_ack[3];
    end
    tick();
    core_found = '0;
    #1;
    checks++; if (gn_valid !== 1'b1 || gn_nonce !== 32'hA3A30003) begin errors++; $display("FAIL arb_second: got %b %h expected 1 a3a30003", gn_valid, gn_nonce); end
    checks++; if (acks1 != 1 || acks3 != 1) begin errors++; $display("FAIL arb_ack_count: got %0d/%0d expected 1/1", acks1, acks3); end
    tick();
    checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL arb_drain: got %b expected 0", gn_valid); end
  endtask

  task automatic test_gn_stream();
    logic [31:0]   q [$];
    logic [31:0]   pend [NC];
    logic [31:0]   prev, want;
    logic [NC-1:0] acked;
    bit            prev_hold;
    int            seq;
    seq = 0; prev_hold = 1'b0; acked = '0; prev = '0;
    for (int c = 0; c < 300; c++) begin
      tick();
      core_found = core_found & ~acked;
      for (int i = 0; i < NC; i++) begin
        if (!core_found[i] && c < 260 && $urandom_range(0, 2) == 0) begin
          pend[i] = {seq[15:0], 16'($urandom)};
          seq++;
          core_golden[32*i +: 32] = pend[i];
          core_found[i] = 1'b1;
        end
      end
      gn_ready = (c >= 260) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) begin
        checks++; if (gn_valid !== 1'b1 || gn_nonce !== prev) begin errors++; $display("FAIL stream_stable: got %b %h expected 1 %h", gn_valid, gn_nonce, prev); end
      end
      if (gn_valid === 1'b1 && gn_ready) begin
        want = (q.size() > 0) ? q.pop_front() : 32'hXXXXXXXX;
        checks++; if (gn_nonce !== want) begin errors++; $display("FAIL stream_order: got %h expected %h", gn_nonce, want); end
      end
      checks++; if ((core_ack & ~core_found) !== '0) begin errors++; $display("FAIL stream_spurious_ack: got %b expected subset of %b", core_ack, core_found); end
      acked = core_ack;
      for (int i = 0; i < NC; i++) if (acked[i]) q.push_back(pend[i]);
      prev_hold = gn_valid && !gn_ready;
      prev = gn_nonce;
    end
    checks++; if (q.size() != 0 || gn_valid !== 1'b0) begin errors++; $display("FAIL stream_leftover: got %0d pending expected 0", q.size()); end
    core_found = '0;
  endtask

  task automatic test_abort();
    logic [NC-1:0] mask_b;
    start_job(32'h00000000, 32'h0000FFFF, "abort_old");
    tick(); core_busy = exp_mask;
    tick(); tick();
    drive_job(32'h10000000, 32'h1000FFFF);
    mask_b = exp_mask;
    core_found = 4'b0100;
    core_golden[64 +: 32] = 32'hDEAD0001;
    #1;
    checks++; if (core_abort !== 4'b1111 || job_ready !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b ready %b expected 1111 ready 1", core_abort, job_ready); end
    checks++; if (core_ack !== 4'b0100) begin errors++; $display("FAIL abort_ack_drop: got %b expected 0100", core_ack); end
    tick();
    job_valid = 1'b0; core_found = '0; core_busy = '0;
    #1;
    checks++; if (core_abort !== '0 || core_start !== '0 || job_done !== 1'b0 || gn_valid !== 1'b0) begin errors++; $display("FAIL abort_split: got %b %b %b %b expected 0 0 0 0", core_abort, core_start, job_done, gn_valid); end
    tick();
    checks++; if (mask_b !== exp_mask) begin errors++; $display("FAIL abort_model: got %b expected %b", exp_mask, mask_b); end
    check_start("abort_new");
    finish_job("abort_new");
  endtask

  task automatic test_reset_mid_run();
    start_job(32'h00001000, 32'h00002000, "rst_run");
    tick(); core_busy = exp_mask;
    tick();
    RST = 1'b1; job_valid = 1'b1;
    #1;
    checks++; if (core_abort !== '0) begin errors++; $display("FAIL rst_no_abort: got %b expected 0000", core_abort); end
    tick();
    RST = 1'b0; job_valid = 1'b0; core_busy = '0;
    checks++; if (job_ready !== 1'b1 || core_start !== '0 || core_nstart !== '0 || core_midstate !== '0) begin errors++; $display("FAIL rst_run_state: got ready %b start %b expected ready 1 start 0", job_ready, core_start); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_min_gt_max();
    test_random_jobs();
    test_arb_order();
    test_gn_stream();
    test_abort();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
